// File: rtl/hotel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hotel_pkg
//  Description : Shared types and rate defaults for the hotel booking engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package hotel_pkg;

    localparam int C_BASE_RATE = 1000;
    localparam int C_AC_RATE   = 500;
    localparam int C_WIFI_RATE = 200;

    // Room entries are stored at these widths; engine parameters must not exceed them.
    localparam int C_ENTRY_ID_W   = 16;
    localparam int C_ENTRY_DAYS_W = 16;
    localparam int C_ENTRY_BILL_W = 32;

    typedef enum logic [2:0] {
        ST_OK        = 3'd0,
        ST_FULL      = 3'd1,
        ST_DUP_ID    = 3'd2,
        ST_NOT_FOUND = 3'd3,
        ST_BAD_REQ   = 3'd4
    } status_e;

    typedef enum logic {
        OP_BOOK     = 1'b0,
        OP_CHECKOUT = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [C_ENTRY_ID_W-1:0]   id;
        logic                      ac;
        logic                      wifi;
        logic [C_ENTRY_DAYS_W-1:0] days_left;
        logic [C_ENTRY_BILL_W-1:0] bill;
    } room_t;

endpackage
`default_nettype wire

// File: rtl/hotel_bill_calc.sv
`default_nettype none
// ============================================================================
//  Module      : hotel_bill_calc
//  Description : Nightly rate sum times stay length, saturated to BILL_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module hotel_bill_calc
    import hotel_pkg::*;
#(
    parameter int DAYS_W    = 3,
    parameter int BILL_W    = 16,
    parameter int BASE_RATE = C_BASE_RATE,
    parameter int AC_RATE   = C_AC_RATE,
    parameter int WIFI_RATE = C_WIFI_RATE
) (
    input  logic              i_ac,
    input  logic              i_wifi,
    input  logic [DAYS_W-1:0] i_days,
    output logic [BILL_W-1:0] o_bill
);

    localparam int PROD_W = 32 + DAYS_W;

    logic [31:0]       w_rate;
    logic [PROD_W-1:0] w_prod;
    logic              w_ovf;

    always_comb begin
        w_rate = 32'(BASE_RATE)
               + (i_ac   ? 32'(AC_RATE)   : 32'd0)
               + (i_wifi ? 32'(WIFI_RATE) : 32'd0);
        w_prod = PROD_W'(w_rate) * PROD_W'(i_days);
        w_ovf  = |w_prod[PROD_W-1:BILL_W];
        o_bill = w_ovf ? {BILL_W{1'b1}} : w_prod[BILL_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/hotel_booking_engine.sv
`default_nettype none
// ============================================================================
//  Module      : hotel_booking_engine
//  Description : Sequential room-reservation engine with billing and nightly expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module hotel_booking_engine
    import hotel_pkg::*;
#(
    parameter int NUM_ROOMS = 8,
    parameter int ID_W      = 4,
    parameter int DAYS_W    = 3,
    parameter int BILL_W    = 16,
    parameter int BASE_RATE = C_BASE_RATE,
    parameter int AC_RATE   = C_AC_RATE,
    parameter int WIFI_RATE = C_WIFI_RATE,
    localparam int RIDX_W   = $clog2(NUM_ROOMS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [ID_W-1:0]      req_id,
    input  logic                 req_ac,
    input  logic                 req_wifi,
    input  logic [DAYS_W-1:0]    req_days,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2:0]           resp_status,
    output logic [RIDX_W-1:0]    resp_room,
    output logic [BILL_W-1:0]    resp_bill,
    input  logic                 night_tick,
    output logic [NUM_ROOMS-1:0] room_occupied,
    output logic [RIDX_W:0]      occ_count,
    output logic                 tick_overrun
);

    localparam int CNT_W = RIDX_W + 1;

    state_e              r_state;
    logic [RIDX_W-1:0]   r_scan_idx;
    op_e                 r_op;
    logic [ID_W-1:0]     r_id;
    logic                r_ac;
    logic                r_wifi;
    logic [DAYS_W-1:0]   r_days;
    logic                r_free_found;
    logic [RIDX_W-1:0]   r_free_idx;
    logic                r_match_found;
    logic [RIDX_W-1:0]   r_match_idx;
    room_t               r_table [NUM_ROOMS];
    logic                r_tick_pending;
    logic                r_tick_overrun;
    logic                r_resp_valid;
    status_e             r_resp_status;
    logic [RIDX_W-1:0]   r_resp_room;
    logic [BILL_W-1:0]   r_resp_bill;
    logic [NUM_ROOMS-1:0] r_occ_map;
    logic [CNT_W-1:0]    r_occ_cnt;

    logic                w_ready;
    logic                w_accept;
    logic                w_tick_now;
    logic                w_scan_occ;
    logic                w_scan_hit;
    logic [BILL_W-1:0]   w_bill;
    status_e             w_status;
    logic [RIDX_W-1:0]   w_room;
    logic [BILL_W-1:0]   w_out_bill;
    logic [NUM_ROOMS-1:0] w_occ_map;
    logic [CNT_W-1:0]    w_occ_cnt;

    hotel_bill_calc #(
        .DAYS_W    (DAYS_W),
        .BILL_W    (BILL_W),
        .BASE_RATE (BASE_RATE),
        .AC_RATE   (AC_RATE),
        .WIFI_RATE (WIFI_RATE)
    ) u_bill_calc (
        .i_ac   (r_ac),
        .i_wifi (r_wifi),
        .i_days (r_days),
        .o_bill (w_bill)
    );

    // A tick seen in IDLE (fresh or pending) owns the table this cycle, so no request is taken.
    assign w_ready    = rst_n && (r_state == S_IDLE) && !r_tick_pending && !night_tick;
    assign w_accept   = req_valid && w_ready;
    assign w_tick_now = (r_state == S_IDLE) && (night_tick || r_tick_pending);

    assign w_scan_occ = (r_table[r_scan_idx].id != '0);
    assign w_scan_hit = w_scan_occ && (r_table[r_scan_idx].id == C_ENTRY_ID_W'(r_id));

    always_comb begin
        w_status   = ST_OK;
        w_room     = '0;
        w_out_bill = '0;
        if (r_op == OP_BOOK) begin
            if ((r_id == '0) || (r_days == '0)) begin
                w_status = ST_BAD_REQ;
            end else if (r_match_found) begin
                w_status = ST_DUP_ID;
            end else if (!r_free_found) begin
                w_status = ST_FULL;
            end else begin
                w_room     = r_free_idx;
                w_out_bill = w_bill;
            end
        end else begin
            if (r_id == '0) begin
                w_status = ST_BAD_REQ;
            end else if (!r_match_found) begin
                w_status = ST_NOT_FOUND;
            end else begin
                w_room     = r_match_idx;
                w_out_bill = r_table[r_match_idx].bill[BILL_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_scan_idx     <= '0;
            r_op           <= OP_BOOK;
            r_id           <= '0;
            r_ac           <= 1'b0;
            r_wifi         <= 1'b0;
            r_days         <= '0;
            r_free_found   <= 1'b0;
            r_free_idx     <= '0;
            r_match_found  <= 1'b0;
            r_match_idx    <= '0;
            r_tick_pending <= 1'b0;
            r_tick_overrun <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_status  <= ST_OK;
            r_resp_room    <= '0;
            r_resp_bill    <= '0;
            for (int i = 0; i < NUM_ROOMS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            if (w_tick_now) begin
                r_tick_pending <= 1'b0;
                if (night_tick && r_tick_pending) begin
                    r_tick_overrun <= 1'b1;
                end
                for (int i = 0; i < NUM_ROOMS; i++) begin
                    if (r_table[i].id != '0) begin
                        if (r_table[i].days_left <= C_ENTRY_DAYS_W'(1)) begin
                            r_table[i] <= '0;
                        end else begin
                            r_table[i].days_left <= r_table[i].days_left - C_ENTRY_DAYS_W'(1);
                        end
                    end
                end
            end else if (night_tick) begin
                if (r_tick_pending) begin
                    r_tick_overrun <= 1'b1;
                end else begin
                    r_tick_pending <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op          <= op_e'(req_op);
                        r_id          <= req_id;
                        r_ac          <= req_ac;
                        r_wifi        <= req_wifi;
                        r_days        <= req_days;
                        r_scan_idx    <= '0;
                        r_free_found  <= 1'b0;
                        r_free_idx    <= '0;
                        r_match_found <= 1'b0;
                        r_match_idx   <= '0;
                        r_state       <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_scan_hit) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_scan_idx;
                    end
                    if (!w_scan_occ && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_scan_idx;
                    end
                    if (r_scan_idx == RIDX_W'(NUM_ROOMS - 1)) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_scan_idx <= r_scan_idx + RIDX_W'(1);
                    end
                end
                S_COMMIT: begin
                    if (w_status == ST_OK) begin
                        if (r_op == OP_BOOK) begin
                            r_table[w_room] <= '{
                                id:        C_ENTRY_ID_W'(r_id),
                                ac:        r_ac,
                                wifi:      r_wifi,
                                days_left: C_ENTRY_DAYS_W'(r_days),
                                bill:      C_ENTRY_BILL_W'(w_bill)
                            };
                        end else begin
                            r_table[w_room] <= '0;
                        end
                    end
                    r_resp_valid  <= 1'b1;
                    r_resp_status <= w_status;
                    r_resp_room   <= w_room;
                    r_resp_bill   <= w_out_bill;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid  <= 1'b0;
                        r_resp_status <= ST_OK;
                        r_resp_room   <= '0;
                        r_resp_bill   <= '0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_occ_map = '0;
        w_occ_cnt = '0;
        for (int i = 0; i < NUM_ROOMS; i++) begin
            w_occ_map[i] = (r_table[i].id != '0);
            w_occ_cnt    = w_occ_cnt + CNT_W'(w_occ_map[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ_map <= '0;
            r_occ_cnt <= '0;
        end else begin
            r_occ_map <= w_occ_map;
            r_occ_cnt <= w_occ_cnt;
        end
    end

    assign req_ready     = w_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_status   = r_resp_status;
    assign resp_room     = r_resp_room;
    assign resp_bill     = r_resp_bill;
    assign room_occupied = r_occ_map;
    assign occ_count     = r_occ_cnt;
    assign tick_overrun  = r_tick_overrun;

endmodule
`default_nettype wire
